// File: rtl/window_energy_integrator.sv
// window_energy_integrator
// Accumulates the squared signed samples between int_start/int_stop window markers
// and counts the valid samples, both saturating. On window close the energy sum,
// sample count and saturation flag are published with a one-cycle out_valid strobe.
// Optional feature macro: WINDOW_MEAN_DIV_EN adds a serial restoring divider
// (one quotient bit per cycle) and the out_mean = out_sum / out_count port.
module window_energy_integrator #(
  parameter int DATA_WIDTH = 24,
  parameter int ACC_WIDTH  = 64,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_data_valid,
  input  logic                  int_start,
  input  logic                  int_stop,
  output logic                  busy,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [REG_WIDTH-1:0]  out_count,
`ifdef WINDOW_MEAN_DIV_EN
  output logic [ACC_WIDTH-1:0]  out_mean,
`endif
  output logic                  out_sat
);

  localparam int SQ_W = 2 * DATA_WIDTH;

`ifdef WINDOW_MEAN_DIV_EN
  localparam int ITER_W = $clog2(ACC_WIDTH);
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAccum   = 3'd1,
    StDivLoad = 3'd2,
    StDivIter = 3'd3,
    StDone    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAccum = 3'd1,
    StDone  = 3'd4
  } state_t;
`endif

  state_t                r_state;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [REG_WIDTH-1:0]  r_cnt;
  logic                  r_sat;

  // Squaring: sign-extend first so the product is formed at full 2*DATA_WIDTH width.
  logic signed [SQ_W-1:0] w_data_ext;
  logic signed [SQ_W-1:0] w_sq_signed;
  logic [ACC_WIDTH-1:0]   w_square;
  assign w_data_ext  = SQ_W'($signed(in_data));
  assign w_sq_signed = w_data_ext * w_data_ext;
  assign w_square    = ACC_WIDTH'($unsigned(w_sq_signed));

  // A window (re)opens either from IDLE or by a restart without a concurrent stop.
  logic w_clear;
  logic w_take;
  assign w_clear = int_start && ((r_state == StIdle) || ((r_state == StAccum) && !int_stop));
  assign w_take  = ((r_state == StIdle) && int_start) || (r_state == StAccum);

  logic [ACC_WIDTH-1:0] w_acc_base;
  logic [REG_WIDTH-1:0] w_cnt_base;
  logic                 w_sat_base;
  assign w_acc_base = w_clear ? '0 : r_acc;
  assign w_cnt_base = w_clear ? '0 : r_cnt;
  assign w_sat_base = w_clear ? 1'b0 : r_sat;

  // Saturating adders: the extra top bit is the overflow indicator.
  logic [ACC_WIDTH:0]   w_acc_sum;
  logic [REG_WIDTH:0]   w_cnt_sum;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [REG_WIDTH-1:0] w_cnt_next;
  logic                 w_sat_next;
  assign w_acc_sum  = {1'b0, w_acc_base} + {1'b0, w_square};
  assign w_cnt_sum  = {1'b0, w_cnt_base} + {{REG_WIDTH{1'b0}}, 1'b1};
  assign w_acc_next = !in_data_valid  ? w_acc_base :
                      w_acc_sum[ACC_WIDTH] ? '1 : w_acc_sum[ACC_WIDTH-1:0];
  assign w_cnt_next = !in_data_valid  ? w_cnt_base :
                      w_cnt_sum[REG_WIDTH] ? '1 : w_cnt_sum[REG_WIDTH-1:0];
  assign w_sat_next = w_sat_base |
                      (in_data_valid & (w_acc_sum[ACC_WIDTH] | w_cnt_sum[REG_WIDTH]));

  assign busy = (r_state != StIdle);

`ifdef WINDOW_MEAN_DIV_EN
  logic [ACC_WIDTH-1:0] r_quo;
  logic [ACC_WIDTH-1:0] r_div;
  logic [ACC_WIDTH-1:0] r_rem;
  logic [ITER_W-1:0]    r_iter;

  // Restoring step: shift the next dividend bit (held in r_quo's MSB) into the remainder.
  // A zero divisor always compares true, which yields the all-ones quotient.
  logic [ACC_WIDTH:0]   w_rem_sh;
  logic                 w_rem_ge;
  logic [ACC_WIDTH-1:0] w_rem_new;
  assign w_rem_sh  = {r_rem, r_quo[ACC_WIDTH-1]};
  assign w_rem_ge  = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_new = w_rem_ge ? (w_rem_sh[ACC_WIDTH-1:0] - r_div) : w_rem_sh[ACC_WIDTH-1:0];
`endif

  // Window FSM, accumulator, optional divider and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
`ifdef WINDOW_MEAN_DIV_EN
      r_quo     <= '0;
      r_div     <= '0;
      r_rem     <= '0;
      r_iter    <= '0;
      out_mean  <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (w_take) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
        r_sat <= w_sat_next;
      end
      case (r_state)
        StIdle: begin
          if (int_start) r_state <= StAccum;
        end
        StAccum: begin
`ifdef WINDOW_MEAN_DIV_EN
          if (int_stop) r_state <= StDivLoad;
`else
          if (int_stop) r_state <= StDone;
`endif
        end
`ifdef WINDOW_MEAN_DIV_EN
        StDivLoad: begin
          r_quo  <= r_acc;
          r_div  <= ACC_WIDTH'(r_cnt);
          r_rem  <= '0;
          r_iter <= '0;
          if (r_cnt == '0) r_sat <= 1'b1;
          r_state <= StDivIter;
        end
        StDivIter: begin
          r_rem  <= w_rem_new;
          r_quo  <= {r_quo[ACC_WIDTH-2:0], w_rem_ge};
          r_iter <= r_iter + 1'b1;
          if (r_iter == ITER_W'(ACC_WIDTH - 1)) r_state <= StDone;
        end
`endif
        StDone: begin
          out_sum   <= r_acc;
          out_count <= r_cnt;
          out_sat   <= r_sat;
`ifdef WINDOW_MEAN_DIV_EN
          out_mean  <= r_quo;
`endif
          out_valid <= 1'b1;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_window_energy_integrator.sv
// Self-checking bench for window_energy_integrator: directed test-plan windows plus
// randomized windows on a default-size instance and a narrow (8/16-bit) instance,
// checked against a sample-list reference model.
module tb_window_energy_integrator;

`ifdef WINDOW_MEAN_DIV_EN
  localparam int LAT_M = 64 + 2;
  localparam int LAT_S = 16 + 2;
`else
  localparam int LAT_M = 1;
  localparam int LAT_S = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [23:0] d_data;
  logic        d_valid, d_start, d_stop;
  bit          sel_small;

  logic        m_valid, m_start, m_stop;
  logic        s_valid, s_start, s_stop;
  assign m_valid = d_valid & ~sel_small;
  assign m_start = d_start & ~sel_small;
  assign m_stop  = d_stop  & ~sel_small;
  assign s_valid = d_valid &  sel_small;
  assign s_start = d_start &  sel_small;
  assign s_stop  = d_stop  &  sel_small;

  logic        m_busy, m_out_valid, m_out_sat;
  logic [63:0] m_out_sum, m_out_mean;
  logic [31:0] m_out_count;
  logic        s_busy, s_out_valid, s_out_sat;
  logic [15:0] s_out_sum, s_out_mean;
  logic [31:0] s_out_count;

`ifndef WINDOW_MEAN_DIV_EN
  assign m_out_mean = '0;
  assign s_out_mean = '0;
`endif

  window_energy_integrator dut_m (
    .clk           (clk),
    .rst           (rst),
    .in_data       (d_data),
    .in_data_valid (m_valid),
    .int_start     (m_start),
    .int_stop      (m_stop),
    .busy          (m_busy),
    .out_valid     (m_out_valid),
    .out_sum       (m_out_sum),
    .out_count     (m_out_count),
`ifdef WINDOW_MEAN_DIV_EN
    .out_mean      (m_out_mean),
`endif
    .out_sat       (m_out_sat)
  );

  window_energy_integrator #(
    .DATA_WIDTH (8),
    .ACC_WIDTH  (16),
    .REG_WIDTH  (32)
  ) dut_s (
    .clk           (clk),
    .rst           (rst),
    .in_data       (d_data[7:0]),
    .in_data_valid (s_valid),
    .int_start     (s_start),
    .int_stop      (s_stop),
    .busy          (s_busy),
    .out_valid     (s_out_valid),
    .out_sum       (s_out_sum),
    .out_count     (s_out_count),
`ifdef WINDOW_MEAN_DIV_EN
    .out_mean      (s_out_mean),
`endif
    .out_sat       (s_out_sat)
  );

  typedef struct {
    bit start;
    bit stop;
    bit valid;
    int val;
  } cyc_t;

  cyc_t         seq[$];
  int           win[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [127:0] e_sum, e_cnt, e_mean;
  logic         e_sat;

  function automatic logic [127:0] o_sum();
    return sel_small ? 128'(s_out_sum) : 128'(m_out_sum);
  endfunction
  function automatic logic [127:0] o_cnt();
    return sel_small ? 128'(s_out_count) : 128'(m_out_count);
  endfunction
  function automatic logic [127:0] o_mean();
    return sel_small ? 128'(s_out_mean) : 128'(m_out_mean);
  endfunction
  function automatic logic o_sat();
    return sel_small ? s_out_sat : m_out_sat;
  endfunction
  function automatic logic o_busy();
    return sel_small ? s_busy : m_busy;
  endfunction
  function automatic logic o_valid();
    return sel_small ? s_out_valid : m_out_valid;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input bit st, input bit sp, input bit v, input int val);
    cyc_t c;
    c.start = st;
    c.stop  = sp;
    c.valid = v;
    c.val   = val;
    seq.push_back(c);
  endtask

  function automatic int rand_val();
    logic [7:0]  b;
    logic [23:0] w;
    b = 8'($urandom);
    w = 24'($urandom);
    if (sel_small) begin
      if ($urandom_range(0, 3) == 0) return -128;
      return int'($signed(b));
    end
    return int'($signed(w));
  endfunction

  task automatic clear_drives();
    d_start = 1'b0;
    d_stop  = 1'b0;
    d_valid = 1'b0;
    d_data  = '0;
  endtask

  // Drives seq; the model keeps the list of samples belonging to the live window.
  task automatic drive_seq(input string tag);
    bit           open;
    int           acc_w;
    logic [127:0] tot, maxv;
    open  = 1'b0;
    acc_w = sel_small ? 16 : 64;
    win.delete();
    foreach (seq[i]) begin
      @(negedge clk);
      check({tag, ".busy"}, 128'(o_busy()), 128'(open));
      d_start = seq[i].start;
      d_stop  = seq[i].stop;
      d_valid = seq[i].valid;
      d_data  = 24'(seq[i].val);
      if (!open) begin
        if (seq[i].start) begin
          open = 1'b1;
          win.delete();
          if (seq[i].valid) win.push_back(seq[i].val);
        end
      end else begin
        if (seq[i].start && !seq[i].stop) win.delete();
        if (seq[i].valid) win.push_back(seq[i].val);
        if (seq[i].stop) open = 1'b0;
      end
    end
    tot = '0;
    foreach (win[j]) tot += 128'(longint'(win[j]) * longint'(win[j]));
    maxv  = (128'(1) << acc_w) - 128'(1);
    e_sat = (tot > maxv);
    e_sum = e_sat ? maxv : tot;
    e_cnt = 128'(win.size());
`ifdef WINDOW_MEAN_DIV_EN
    if (e_cnt == 0) begin
      e_mean = maxv;
      e_sat  = 1'b1;
    end else begin
      e_mean = e_sum / e_cnt;
    end
`else
    e_mean = '0;
`endif
  endtask

  // Waits (bounded) for the result strobe, then checks latency and results.
  task automatic finish_seq(input string tag);
    int lat;
    int k;
    lat = sel_small ? LAT_S : LAT_M;
    @(posedge clk);
    #1;
    clear_drives();
    check({tag, ".busy_close"}, 128'(o_busy()), 128'(1));
    k = 0;
    while (k < lat + 10) begin
      @(posedge clk);
      #1;
      k++;
      if (o_valid()) break;
      d_valid = 1'($urandom);
      d_data  = 24'($urandom);
    end
    check({tag, ".latency"}, 128'(k), 128'(lat));
    check({tag, ".sum"}, o_sum(), e_sum);
    check({tag, ".count"}, o_cnt(), e_cnt);
    check({tag, ".sat"}, 128'(o_sat()), 128'(e_sat));
`ifdef WINDOW_MEAN_DIV_EN
    check({tag, ".mean"}, o_mean(), e_mean);
`endif
    @(posedge clk);
    #1;
    check({tag, ".valid_pulse"}, 128'(o_valid()), 128'(0));
    check({tag, ".busy_idle"}, 128'(o_busy()), 128'(0));
    clear_drives();
  endtask

  task automatic run_seq(input string tag);
    drive_seq(tag);
    finish_seq(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".m_busy"}, 128'(m_busy), 128'(0));
    check({tag, ".m_valid"}, 128'(m_out_valid), 128'(0));
    check({tag, ".m_sum"}, 128'(m_out_sum), 128'(0));
    check({tag, ".m_count"}, 128'(m_out_count), 128'(0));
    check({tag, ".m_mean"}, 128'(m_out_mean), 128'(0));
    check({tag, ".m_sat"}, 128'(m_out_sat), 128'(0));
    check({tag, ".s_sum"}, 128'(s_out_sum), 128'(0));
    check({tag, ".s_sat"}, 128'(s_out_sat), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int len;
    rst = 1'b1;
    sel_small = 1'b0;
    clear_drives();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 10 samples of +3, stop on the 10th.
    seq.delete();
    add(1, 0, 1, 3);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 3);
    add(0, 1, 1, 3);
    run_seq("plus3");

    // 5 samples of -4 with the qualifier toggling; invalid cycles carry junk data.
    seq.delete();
    for (int i = 0; i < 10; i++) add(i == 0, i == 9, (i % 2) == 0, (i % 2) == 0 ? -4 : 1000);
    run_seq("minus4");

    // Narrow instance saturation: 5 samples of -128 overflow a 16-bit accumulator.
    sel_small = 1'b1;
    seq.delete();
    add(1, 0, 1, -128);
    for (int i = 0; i < 3; i++) add(0, 0, 1, -128);
    add(0, 1, 1, -128);
    run_seq("sat8");
    sel_small = 1'b0;

    // Empty window: start then stop, no valid samples; stop while idle is ignored.
    seq.delete();
    add(0, 1, 1, 7);
    add(1, 0, 0, 5);
    add(0, 1, 0, 5);
    run_seq("empty");

    // Restart after 3 samples of 2, then 4 samples of 1.
    seq.delete();
    add(1, 0, 1, 2);
    add(0, 0, 1, 2);
    add(0, 0, 1, 2);
    add(1, 0, 1, 1);
    add(0, 0, 1, 1);
    add(0, 0, 1, 1);
    add(0, 1, 1, 1);
    run_seq("restart");

    // Same-cycle start+stop inside a window closes it.
    seq.delete();
    add(1, 0, 1, 5);
    add(0, 0, 1, 6);
    add(1, 1, 1, 7);
    run_seq("startstop");

    // Reset mid-window (or in the 5th divider iteration) aborts with no strobe.
    seq.delete();
    add(1, 0, 1, 9);
    add(0, 0, 1, 9);
`ifdef WINDOW_MEAN_DIV_EN
    add(0, 1, 1, 9);
`else
    add(0, 0, 1, 9);
`endif
    drive_seq("abort");
    @(posedge clk);
`ifdef WINDOW_MEAN_DIV_EN
    repeat (5) @(posedge clk);
`endif
    #1;
    clear_drives();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT_M + 10; i++) begin
      @(posedge clk);
      #1;
      if (m_out_valid || s_out_valid) seen++;
    end
    check("abort.no_valid", 128'(seen), 128'(0));

    // Next window after the abort completes normally.
    seq.delete();
    add(1, 0, 1, -3);
    add(0, 0, 1, 100);
    add(0, 1, 1, -50);
    run_seq("after_abort");

    // Randomized windows on both instances.
    for (int w = 0; w < 24; w++) begin
      sel_small = 1'($urandom);
      seq.delete();
      if ($urandom_range(0, 3) == 0) add(0, 1, 1, rand_val());
      len = $urandom_range(2, 10);
      for (int i = 0; i < len; i++) begin
        bit st, sp;
        sp = (i == len - 1);
        st = (i == 0) || ($urandom_range(0, 6) == 0);
        add(st, sp, $urandom_range(0, 3) != 0, rand_val());
      end
      run_seq(sel_small ? "rand_s" : "rand_m");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
